program_loader: RTL and testbench
=================================

// Module: program_loader
//
// PURPOSE
//  Writer side of the processor's instruction-memory array. Accepts a byte stream over a valid/ready
//  handshake, zero-clears then fills instructions[0:MEM_SIZE-1] from address 0, and holds the processor
//  in reset (cpu_rst_n low) until a full program has loaded. Sits between the host/test stream and the
//  processor's instructions input and active-low rst input.
//
// PARAMETERS
//  ADDR_WIDTH  6                 instruction address width; must match the processor
//  DATA_WIDTH  8                 instruction word width: [7:5] opcode, [4:0] operands
//  MEM_SIZE    2**ADDR_WIDTH     number of instruction words
//
// PORTS
//  clk           in   1                       single clock, all state on posedge
//  rst           in   1                       asynchronous, active-low reset
//  start         in   1                       1-cycle request; honoured in IDLE, DONE and ERR only
//  in_valid      in   1                       stream byte valid
//  in_data       in   DATA_WIDTH              stream byte (instruction word)
//  in_last       in   1                       qualifies the final byte of the program
//  in_ready      out  1                       loader accepts a byte this cycle
//  instructions  out  DATA_WIDTH x MEM_SIZE   unpacked [0:MEM_SIZE-1]; drives processor instruction input
//  cpu_rst_n     out  1                       processor reset, active-low; high only in DONE
//  load_count    out  ADDR_WIDTH+1            bytes accepted in current/last load
//  done          out  1                       program loaded, processor released
//  error         out  1                       overflow: MEM_SIZE bytes accepted without in_last
//
// BEHAVIOUR
//  - Reset (rst low, async): state IDLE; every instructions[i]=0; cpu_rst_n=0; in_ready=0; done=0;
//    error=0; load_count=0; wr_addr=0. All outputs registered.
//  - States: IDLE, CLEAR, LOAD, DONE, ERR.
//  - IDLE: start -> CLEAR. Stream ignored.
//  - CLEAR: one word zeroed per cycle at clr_addr 0..MEM_SIZE-1 (MEM_SIZE cycles); done=0, error=0,
//    load_count=0, cpu_rst_n=0 from first CLEAR cycle; after clr_addr==MEM_SIZE-1 -> LOAD.
//    start seen in IDLE at edge t: CLEAR cycles t+1..t+MEM_SIZE, LOAD from t+MEM_SIZE+1.
//  - LOAD: in_ready=1. Transfer = in_valid && in_ready at posedge: instructions[wr_addr]<=in_data,
//    wr_addr++, load_count++. Written word visible cycle after the transfer. in_valid low = stall,
//    no state change. in_data/in_last ignored unless in_valid.
//  - Transfer with in_last -> DONE (in_ready low next cycle). Transfer at wr_addr==MEM_SIZE-1 with
//    in_last=0 -> ERR (word still written); with in_last=1 -> DONE (exactly-full program is legal).
//  - wr_addr never wraps; no transfer accepted outside LOAD.
//  - DONE: done=1, cpu_rst_n=1, in_ready=0; instructions held stable. start -> CLEAR (cpu_rst_n
//    drops the next cycle, old program zeroed).
//  - ERR: error=1, cpu_rst_n=0, in_ready=0; memory keeps partial contents. start -> CLEAR.
//  - start in CLEAR or LOAD ignored (no restart, no abort). start and a transfer in same cycle: transfer wins.
//  - rst low mid-CLEAR/LOAD/DONE: immediate return to reset values, program discarded.
//  - done and error never both 1; cpu_rst_n==1 iff state==DONE.
//
// TESTING
//  1 Reset: rst low -> all instructions 0, cpu_rst_n=0, in_ready=0, done=0, error=0, load_count=0.
//  2 Short load: start; after 64 CLEAR cycles send 8'h21,8'h45,8'h83(last) back-to-back ->
//    instructions[0..2]=21,45,83, [3..63]=0, load_count=3, done=1, cpu_rst_n=1.
//  3 Backpressure: in_valid toggled 1,0,0,1,0,1(last) with bytes 10,11,12 -> exactly 3 words written,
//    stalls cause no writes, load_count=3.
//  4 Boundary: 64 bytes, in_last on 64th -> done=1, instructions[63]=64th byte; 64 bytes no in_last ->
//    error=1, cpu_rst_n=0, in_ready=0, 65th byte not accepted.
//  5 Reload: after test 2 DONE, start -> cpu_rst_n=0 next cycle, old words zeroed; load 8'h9F(last) ->
//    instructions[0]=9F, [1..2]=0, load_count=1; start during CLEAR/LOAD has no effect.
//  6 Reset mid-LOAD: rst low after 2 transfers -> memory all 0, state IDLE, in_ready=0 asynchronously.

Source files
------------

// File: rtl/program_loader.sv
// Instruction-memory writer: zero-clears the array, fills it from a valid/ready byte stream,
// and holds the processor in reset until a complete program has been loaded.
module program_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] instructions [0:MEM_SIZE-1],
  output logic                  cpu_rst_n,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_addr_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [ADDR_WIDTH:0]     load_count_q;
  logic [DATA_WIDTH-1:0]   mem_q [0:MEM_SIZE-1];
  logic                    in_ready_q;
  logic                    done_q;
  logic                    error_q;
  logic                    cpu_rst_n_q;
  logic                    xfer_s;

  // in_ready_q is only ever set while in LOAD, so it alone qualifies a transfer
  assign xfer_s = in_valid && in_ready_q;

  // Loader FSM: every output is a register updated alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      clr_addr_q   <= '0;
      wr_addr_q    <= '0;
      load_count_q <= '0;
      in_ready_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_CLEAR;
            clr_addr_q   <= '0;
            wr_addr_q    <= '0;
            load_count_q <= '0;
            in_ready_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
          end
        end
        S_CLEAR: begin
          mem_q[clr_addr_q] <= '0;
          clr_addr_q        <= clr_addr_q + ADDR_WIDTH'(1);
          if (clr_addr_q == LAST_ADDR) begin
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (xfer_s) begin
            mem_q[wr_addr_q] <= in_data;
            load_count_q     <= load_count_q + (ADDR_WIDTH + 1)'(1);
            // Hold the address at the top word so it never wraps back to zero
            if (wr_addr_q != LAST_ADDR) begin
              wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
            end
            if (in_last) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              done_q      <= 1'b1;
              cpu_rst_n_q <= 1'b1;
            end else if (wr_addr_q == LAST_ADDR) begin
              state_q    <= S_ERR;
              in_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          done_q      <= 1'b0;
          error_q     <= 1'b0;
          cpu_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign instructions = mem_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign load_count   = load_count_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: clear/fill timing, backpressure,
// exact-full and overflow boundaries, reload and asynchronous reset.
module tb_program_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [7:0] instr [0:63];
  logic       cpu_rst_n;
  logic [6:0] load_count;
  logic       done;
  logic       error;

  logic [7:0] exp_mem [0:63];
  int total;
  int bad;

  program_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .instructions (instr),
    .cpu_rst_n    (cpu_rst_n),
    .load_count   (load_count),
    .done         (done),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;
  endtask

  task automatic check_mem(input string name);
    int errs;
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      if (instr[i] !== exp_mem[i]) begin
        if (errs < 4) $display("FAIL %s word[%0d] got %02h expected %02h", name, i, instr[i], exp_mem[i]);
        errs++;
      end
    end
    total++;
    if (errs != 0) bad++;
  endtask

  // Pulse start for one cycle, then count cycles until in_ready rises
  task automatic start_and_wait(input string name, input bit poke_start_in_clear);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (cpu_rst_n !== 1'b0 || done !== 1'b0 || error !== 1'b0 || load_count !== 7'd0) begin
      $display("FAIL %s first_clear cpu_rst_n=%b done=%b error=%b count=%0d expected 0,0,0,0",
               name, cpu_rst_n, done, error, load_count);
      bad++;
    end
    n = 0;
    if (poke_start_in_clear) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
    end
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n != 64) begin
      $display("FAIL %s clear_cycles got %0d expected 64", name, n);
      bad++;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    clear_exp();
    total++;
    if (cpu_rst_n !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || error !== 1'b0 || load_count !== 7'd0) begin
      $display("FAIL reset outs cpu_rst_n=%b in_ready=%b done=%b error=%b count=%0d expected all 0",
               cpu_rst_n, in_ready, done, error, load_count);
      bad++;
    end
    check_mem("reset_mem");
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) tick();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || load_count !== 7'd0 || instr[0] !== 8'h00) begin
      $display("FAIL idle_ignores_stream in_ready=%b count=%0d word0=%02h expected 0,0,00",
               in_ready, load_count, instr[0]);
      bad++;
    end
  endtask

  task automatic test_short_load();
    start_and_wait("short", 1'b0);
    send(8'h21, 1'b0);
    send(8'h45, 1'b0);
    send(8'h83, 1'b1);
    clear_exp();
    exp_mem[0] = 8'h21; exp_mem[1] = 8'h45; exp_mem[2] = 8'h83;
    total++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1 || error !== 1'b0 || in_ready !== 1'b0 || load_count !== 7'd3) begin
      $display("FAIL short status done=%b cpu_rst_n=%b error=%b in_ready=%b count=%0d expected 1,1,0,0,3",
               done, cpu_rst_n, error, in_ready, load_count);
      bad++;
    end
    check_mem("short_mem");
  endtask

  task automatic test_reload();
    start_and_wait("reload", 1'b1);
    clear_exp();
    check_mem("reload_cleared");
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (in_ready !== 1'b1 || load_count !== 7'd0 || done !== 1'b0) begin
      $display("FAIL reload start_in_load in_ready=%b count=%0d done=%b expected 1,0,0", in_ready, load_count, done);
      bad++;
    end
    start = 1'b1;
    send(8'h9F, 1'b1);
    start = 1'b0;
    exp_mem[0] = 8'h9F;
    total++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1 || load_count !== 7'd1) begin
      $display("FAIL reload status done=%b cpu_rst_n=%b count=%0d expected 1,1,1", done, cpu_rst_n, load_count);
      bad++;
    end
    check_mem("reload_mem");
  endtask

  task automatic test_backpressure();
    logic       v_seq [0:5];
    logic [7:0] b;
    v_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    start_and_wait("bp", 1'b0);
    b = 8'h10;
    for (int i = 0; i < 6; i++) begin
      if (v_seq[i]) begin
        send(b, (b == 8'h12) ? 1'b1 : 1'b0);
        b = b + 8'h01;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        in_last  = 1'b1;
        tick();
        in_last  = 1'b0;
        total++;
        if (load_count !== 7'(b - 8'h10) || done !== 1'b0) begin
          $display("FAIL bp stall%0d count=%0d done=%b expected %0d,0", i, load_count, done, b - 8'h10);
          bad++;
        end
      end
    end
    clear_exp();
    exp_mem[0] = 8'h10; exp_mem[1] = 8'h11; exp_mem[2] = 8'h12;
    total++;
    if (load_count !== 7'd3 || done !== 1'b1) begin
      $display("FAIL bp final count=%0d done=%b expected 3,1", load_count, done);
      bad++;
    end
    check_mem("bp_mem");
  endtask

  task automatic test_full();
    start_and_wait("full", 1'b0);
    for (int i = 0; i < 63; i++) begin
      send(8'(i * 3 + 1), 1'b0);
      exp_mem[i] = 8'(i * 3 + 1);
    end
    total++;
    if (done !== 1'b0 || in_ready !== 1'b1 || load_count !== 7'd63) begin
      $display("FAIL full at63 done=%b in_ready=%b count=%0d expected 0,1,63", done, in_ready, load_count);
      bad++;
    end
    send(8'hC4, 1'b1);
    exp_mem[63] = 8'hC4;
    total++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_rst_n !== 1'b1 || load_count !== 7'd64) begin
      $display("FAIL full status done=%b error=%b cpu_rst_n=%b count=%0d expected 1,0,1,64",
               done, error, cpu_rst_n, load_count);
      bad++;
    end
    check_mem("full_mem");
  endtask

  task automatic test_overflow();
    start_and_wait("ovf", 1'b0);
    for (int i = 0; i < 64; i++) begin
      send(8'(255 - i), 1'b0);
      exp_mem[i] = 8'(255 - i);
    end
    total++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0 || in_ready !== 1'b0 || load_count !== 7'd64) begin
      $display("FAIL ovf status error=%b done=%b cpu_rst_n=%b in_ready=%b count=%0d expected 1,0,0,0,64",
               error, done, cpu_rst_n, in_ready, load_count);
      bad++;
    end
    in_valid = 1'b1;
    in_data  = 8'h3C;
    in_last  = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++;
    if (load_count !== 7'd64 || error !== 1'b1 || done !== 1'b0) begin
      $display("FAIL ovf byte65 count=%0d error=%b done=%b expected 64,1,0", load_count, error, done);
      bad++;
    end
    check_mem("ovf_mem");
  endtask

  task automatic test_reset_mid_load();
    start_and_wait("midrst", 1'b0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    clear_exp();
    total++;
    if (in_ready !== 1'b0 || load_count !== 7'd0 || cpu_rst_n !== 1'b0 || done !== 1'b0) begin
      $display("FAIL midrst async in_ready=%b count=%0d cpu_rst_n=%b done=%b expected 0,0,0,0",
               in_ready, load_count, cpu_rst_n, done);
      bad++;
    end
    check_mem("midrst_mem");
    tick();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (3) tick();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || load_count !== 7'd0 || instr[0] !== 8'h00) begin
      $display("FAIL midrst idle in_ready=%b count=%0d word0=%02h expected 0,0,00", in_ready, load_count, instr[0]);
      bad++;
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    #2;
    test_reset();
    test_short_load();
    test_reload();
    test_backpressure();
    test_full();
    test_overflow();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
